// File: rtl/sips_pkg.sv
// sips_pkg: shared encodings for the sips_core processor.
// Latency: n/a (constants, types and one pure function).
// Backpressure: n/a.
package sips_pkg;

  // Control sequencer states.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEMRD = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  // Major opcodes, instr[15:11]. 0ffff is ALU, 11xxx is NOP.
  localparam logic [4:0] OP_BCC0 = 5'b10000;
  localparam logic [4:0] OP_BCC1 = 5'b10001;
  localparam logic [4:0] OP_JAL  = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b10011;
  localparam logic [4:0] OP_LD   = 5'b10100;
  localparam logic [4:0] OP_ST   = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;

  // ALU function codes, instr[14:11] when instr[15]==0. 11..15 are NOP.
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SHL = 4'd5;
  localparam logic [3:0] ALU_SHR = 4'd6;
  localparam logic [3:0] ALU_SAR = 4'd7;
  localparam logic [3:0] ALU_MOV = 4'd8;
  localparam logic [3:0] ALU_NOT = 4'd9;
  localparam logic [3:0] ALU_CMP = 4'd10;

  // Branch condition codes, instr[10:8] of a Bcc.
  localparam logic [2:0] CC_EQ = 3'd0;  // Z
  localparam logic [2:0] CC_VS = 3'd1;  // V
  localparam logic [2:0] CC_GT = 3'd2;  // ~Z & ~(N^V)
  localparam logic [2:0] CC_GE = 3'd3;  // ~(N^V)
  localparam logic [2:0] CC_HI = 3'd4;  // ~(C|Z)
  localparam logic [2:0] CC_CC = 3'd5;  // ~C
  localparam logic [2:0] CC_MI = 3'd6;  // N
  localparam logic [2:0] CC_AL = 3'd7;  // always

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

  function automatic logic cond_eval(input logic [2:0] cc, input flags_t f);
    logic r;
    case (cc)
      CC_EQ:   r = f.z;
      CC_VS:   r = f.v;
      CC_GT:   r = ~f.z & ~(f.n ^ f.v);
      CC_GE:   r = ~(f.n ^ f.v);
      CC_HI:   r = ~(f.c | f.z);
      CC_CC:   r = ~f.c;
      CC_MI:   r = f.n;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sips_alu.sv
// sips_alu: combinational ALU and {N,Z,V,C} flag generator.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: func (4b code), a/b operands -> result, flags, wr_en (write rd), flag_en (update flags).
module sips_alu
  import sips_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        func,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output flags_t            flags,
  output logic              wr_en,
  output logic              flag_en
);

  logic [DATA_W:0]        sum_x;
  logic [DATA_W:0]        diff_x;
  logic [DATA_W:0]        shl_x;
  logic [DATA_W:0]        shr_x;
  logic signed [DATA_W:0] sar_x;
  logic                   carry;
  logic                   ovf;

  always_comb begin
    // One extra bit catches carry/borrow; for right shifts the extra low
    // bit catches the last bit shifted out (including amounts >= DATA_W).
    sum_x  = {1'b0, a} + {1'b0, b};
    diff_x = {1'b0, a} - {1'b0, b};
    shl_x  = {1'b0, a} << b;
    shr_x  = {a, 1'b0} >> b;
    sar_x  = $signed({a, 1'b0}) >>> b;

    result  = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    wr_en   = (func < ALU_CMP);
    flag_en = (func <= ALU_CMP);

    case (func)
      ALU_ADD: begin
        result = sum_x[DATA_W-1:0];
        carry  = sum_x[DATA_W];
        ovf    = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB, ALU_CMP: begin
        result = diff_x[DATA_W-1:0];
        carry  = diff_x[DATA_W];
        ovf    = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SHL: begin
        result = shl_x[DATA_W-1:0];
        carry  = shl_x[DATA_W];
      end
      ALU_SHR: begin
        result = shr_x[DATA_W:1];
        carry  = shr_x[0];
      end
      ALU_SAR: begin
        result = sar_x[DATA_W:1];
        carry  = sar_x[0];
      end
      ALU_MOV: result = b;
      ALU_NOT: result = ~a;
      default: result = '0;
    endcase

    flags.n = result[DATA_W-1];
    flags.z = (result == '0);
    flags.v = ovf;
    flags.c = carry;
  end

endmodule

// File: rtl/sips_core.sv
// sips_core: multi-cycle processor, 16-bit instructions, 8 regs, port I/O.
// Latency: 2 cycles per instruction (FETCH, EXEC), LD 3 (adds MEMRD); HALT parks until rst.
// Backpressure: none; imem/dmem are fixed one-cycle-latency, no stall input.
// Ports: clk/rst; imem_addr->imem_data (16b, next cycle); dmem_addr/wdata/wen, dmem_rdata
// (next cycle); in_port/out_port packed NPORT x DATA_W; halted.
module sips_core
  import sips_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int NPORT  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [PC_W-1:0]         imem_addr,
  input  logic [15:0]             imem_data,
  output logic [DATA_W-1:0]       dmem_addr,
  output logic [DATA_W-1:0]       dmem_wdata,
  output logic                    dmem_wen,
  input  logic [DATA_W-1:0]       dmem_rdata,
  input  logic [NPORT*DATA_W-1:0] in_port,
  output logic [NPORT*DATA_W-1:0] out_port,
  output logic                    halted
);

  localparam int PSEL_W = (NPORT > 1) ? $clog2(NPORT) : 1;

  state_e                    state_q, state_d;
  logic [PC_W-1:0]           pc_q, pc_d;
  logic [7:0][DATA_W-1:0]    regs_q, regs_d;
  flags_t                    flags_q, flags_d;
  logic [NPORT*DATA_W-1:0]   out_q, out_d;
  logic [2:0]                ld_dst_q, ld_dst_d;

  // Decode straight from imem_data, which is valid throughout EXEC.
  logic [4:0]        op;
  logic [2:0]        rd;
  logic [DATA_W-1:0] a_val;
  logic [DATA_W-1:0] b_val;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   b_pc;
  logic [PSEL_W-1:0] port_sel;
  logic              taken;

  logic [DATA_W-1:0] alu_res;
  flags_t            alu_flags;
  logic              alu_wr;
  logic              alu_flag_en;

  assign op       = imem_data[15:11];
  assign rd       = imem_data[3:1];
  assign a_val    = regs_q[imem_data[10:8]];
  assign b_val    = imem_data[0] ? DATA_W'(imem_data[7:4]) : regs_q[imem_data[6:4]];
  assign pc_inc   = pc_q + 1'b1;
  assign b_pc     = PC_W'(b_val);
  assign port_sel = (NPORT > 1) ? PSEL_W'(b_val) : '0;
  assign taken    = op[0] ^ cond_eval(imem_data[10:8], flags_q);

  sips_alu #(.DATA_W(DATA_W)) u_alu (
    .func    (op[3:0]),
    .a       (a_val),
    .b       (b_val),
    .result  (alu_res),
    .flags   (alu_flags),
    .wr_en   (alu_wr),
    .flag_en (alu_flag_en)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    regs_d     = regs_q;
    flags_d    = flags_q;
    out_d      = out_q;
    ld_dst_d   = ld_dst_q;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_wen   = 1'b0;

    unique case (state_q)
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc;
        if (!op[4]) begin
          if (alu_wr)      regs_d[rd] = alu_res;
          if (alu_flag_en) flags_d    = alu_flags;
        end else begin
          case (op)
            OP_BCC0, OP_BCC1: if (taken) pc_d = b_pc;
            OP_JAL: begin
              regs_d[rd] = DATA_W'(pc_inc);
              pc_d       = b_pc;
            end
            OP_HALT: begin
              pc_d    = pc_q;
              state_d = ST_HALT;
            end
            OP_LD: begin
              // PC advances now; MEMRD only retires the read data.
              dmem_addr = b_val;
              ld_dst_d  = rd;
              state_d   = ST_MEMRD;
            end
            OP_ST: begin
              dmem_addr  = b_val;
              dmem_wdata = a_val;
              dmem_wen   = 1'b1;
            end
            OP_IN:  regs_d[rd] = in_port[port_sel*DATA_W +: DATA_W];
            OP_OUT: out_d[port_sel*DATA_W +: DATA_W] = a_val;
            default: ;  // 11xxx: NOP
          endcase
        end
      end
      ST_MEMRD: begin
        regs_d[ld_dst_q] = dmem_rdata;
        state_d          = ST_FETCH;
      end
      ST_HALT: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= '0;
      regs_q   <= '0;
      flags_q  <= '0;
      out_q    <= '0;
      ld_dst_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      regs_q   <= regs_d;
      flags_q  <= flags_d;
      out_q    <= out_d;
      ld_dst_q <= ld_dst_d;
    end
  end

  assign imem_addr = pc_q;
  assign out_port  = out_q;
  assign halted    = (state_q == ST_HALT);

endmodule
